// File: rtl/unlock_attempt_guard.sv
// Attempt gatekeeper in front of the unlocking system: forwards one code word per attempt,
// counts consecutive failures, enforces lockout and times the door pulse. Optional: ATTEMPT_TIMEOUT_EN.
module unlock_attempt_guard #(
    parameter int N                  = 4,
    parameter int MAX_FAILS          = 3,
    parameter int LOCKOUT_CYCLES     = 1000,
    parameter int UNLOCK_HOLD_CYCLES = 50,
    parameter int RESULT_TIMEOUT     = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N-1:0]                   in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [N-1:0]                   p_data,
    output logic                           p_valid,
    input  logic                           p_ready,
    input  logic                           unlock,
    input  logic                           pwd_incorrect,
    output logic                           door_open,
    output logic                           locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
    output logic                           alarm,
    output logic                           attempt_timeout
);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int HW = $clog2(UNLOCK_HOLD_CYCLES + 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(UNLOCK_HOLD_CYCLES - 1);

    if (MAX_FAILS < 1 || RESULT_TIMEOUT < 1) begin : g_bad_param
        $error("unlock_attempt_guard: MAX_FAILS and RESULT_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, FORWARD, WAIT_RESULT, OPEN, LOCKOUT} state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  hold_reg, hold_next;
    logic [FW-1:0] fail_count_reg, fail_next, fail_inc;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [LW-1:0] lock_cnt_reg, lock_cnt_next;
    logic          fail_event;
    logic          in_ready_reg, in_ready_next;
    logic          p_valid_reg, p_valid_next;
    logic          door_open_reg, door_open_next;
    logic          locked_out_reg, locked_out_next;
    logic          alarm_reg, alarm_next;

    // Bit 0 tracks unlock, bit 1 tracks pwd_incorrect; a result is a rising edge only.
    logic [1:0] result_in;
    logic [1:0] result_edge;
    assign result_in = {pwd_incorrect, unlock};

    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
        logic q_reg;
        always_ff @(posedge clk) begin
            if (rst) q_reg <= 1'b0;
            else     q_reg <= result_in[gi];
        end
        assign result_edge[gi] = result_in[gi] & ~q_reg;
    end

`ifdef ATTEMPT_TIMEOUT_EN
    localparam int WW = $clog2(RESULT_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RESULT_TIMEOUT - 1);
    logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
    logic          timeout_reg, timeout_next;
`endif

    assign fail_inc = (fail_count_reg == FAIL_MAX) ? FAIL_MAX : fail_count_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            fail_count_reg <= '0;
            hold_cnt_reg   <= '0;
            lock_cnt_reg   <= '0;
            in_ready_reg   <= 1'b0;
            p_valid_reg    <= 1'b0;
            door_open_reg  <= 1'b0;
            locked_out_reg <= 1'b0;
            alarm_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            fail_count_reg <= fail_next;
            hold_cnt_reg   <= hold_cnt_next;
            lock_cnt_reg   <= lock_cnt_next;
            in_ready_reg   <= in_ready_next;
            p_valid_reg    <= p_valid_next;
            door_open_reg  <= door_open_next;
            locked_out_reg <= locked_out_next;
            alarm_reg      <= alarm_next;
        end
    end

`ifdef ATTEMPT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end
`endif

    always_comb begin
        state_next    = state_reg;
        hold_next     = hold_reg;
        fail_next     = fail_count_reg;
        hold_cnt_next = hold_cnt_reg;
        lock_cnt_next = lock_cnt_reg;
        alarm_next    = 1'b0;
        fail_event    = 1'b0;
`ifdef ATTEMPT_TIMEOUT_EN
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready_reg) begin
                    hold_next  = in_data;
                    state_next = FORWARD;
                end
            end
            FORWARD: begin
                if (p_valid_reg && p_ready) begin
                    state_next = WAIT_RESULT;
`ifdef ATTEMPT_TIMEOUT_EN
                    wait_cnt_next = '0;
`endif
                end
            end
            WAIT_RESULT: begin
                // A wrong-code edge wins over a simultaneous unlock edge.
                if (result_edge[1]) begin
                    fail_event = 1'b1;
                end else if (result_edge[0]) begin
                    fail_next     = '0;
                    hold_cnt_next = '0;
                    state_next    = OPEN;
                end
`ifdef ATTEMPT_TIMEOUT_EN
                else if (wait_cnt_reg == WAIT_LAST) begin
                    timeout_next = 1'b1;
                    fail_event   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
`endif
            end
            OPEN: begin
                if (hold_cnt_reg == HOLD_LAST) state_next = IDLE;
                else                            hold_cnt_next = hold_cnt_reg + 1'b1;
            end
            LOCKOUT: begin
                if (lock_cnt_reg == LOCK_LAST) begin
                    fail_next  = '0;
                    state_next = IDLE;
                end else begin
                    lock_cnt_next = lock_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (fail_event) begin
            fail_next = fail_inc;
            if (fail_inc == FAIL_MAX) begin
                alarm_next    = 1'b1;
                lock_cnt_next = '0;
                state_next    = LOCKOUT;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // Outputs are registered from the next state so reset forces every one of them low.
    always_comb begin
        in_ready_next   = (state_next == IDLE);
        p_valid_next    = (state_next == FORWARD);
        door_open_next  = (state_next == OPEN);
        locked_out_next = (state_next == LOCKOUT);
    end

    assign in_ready   = in_ready_reg;
    assign p_valid    = p_valid_reg;
    assign p_data     = hold_reg;
    assign door_open  = door_open_reg;
    assign locked_out = locked_out_reg;
    assign fail_count = fail_count_reg;
    assign alarm      = alarm_reg;
`ifdef ATTEMPT_TIMEOUT_EN
    assign attempt_timeout = timeout_reg;
`else
    assign attempt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_unlock_attempt_guard.sv
// Directed bench for unlock_attempt_guard: success, lockout, backpressure, result edges,
// mid-attempt reset and the optional result timeout (ATTEMPT_TIMEOUT_EN).
module tb_unlock_attempt_guard;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] p_data;
    logic       p_valid;
    logic       p_ready;
    logic       unlock;
    logic       pwd_incorrect;
    logic       door_open;
    logic       locked_out;
    logic [1:0] fail_count;
    logic       alarm;
    logic       attempt_timeout;

    int checks = 0;
    int errors = 0;

    unlock_attempt_guard #(
        .N(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(20), .UNLOCK_HOLD_CYCLES(5), .RESULT_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready), .unlock(unlock),
        .pwd_incorrect(pwd_incorrect), .door_open(door_open), .locked_out(locked_out),
        .fail_count(fail_count), .alarm(alarm), .attempt_timeout(attempt_timeout)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word in IDLE and let it be handed off (p_ready already 1): ends in WAIT_RESULT.
    task automatic drive_attempt(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; p_ready = 1'b0; unlock = 1'b0; pwd_incorrect = 1'b0;
        tick(); tick();
        checks++;
        if ({in_ready, p_valid, p_data, door_open, locked_out, fail_count, alarm, attempt_timeout} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got in_ready=%b p_valid=%b p_data=%b door=%b lock=%b fail=%0d alarm=%b to=%b want all 0",
                     in_ready, p_valid, p_data, door_open, locked_out, fail_count, alarm, attempt_timeout);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
        $display("reset: in_ready=%b fail_count=%0d", in_ready, fail_count);
    endtask

    task automatic test_success();
        int opens;
        p_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'b1101;
        tick();
        in_valid = 1'b0;
        checks++;
        if (p_valid !== 1'b1 || p_data !== 4'b1101) begin
            errors++; $display("FAIL success_forward got p_valid=%b p_data=%b want 1 1101", p_valid, p_data);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL success_busy got in_ready=%b want 0", in_ready); end
        tick();
        checks++;
        if (p_valid !== 1'b0) begin errors++; $display("FAIL success_handoff got p_valid=%b want 0", p_valid); end
        tick(); tick();
        unlock = 1'b1;
        tick();
        unlock = 1'b0;
        opens = door_open ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (door_open === 1'b1) opens++;
        end
        checks++;
        if (opens != 5) begin errors++; $display("FAIL success_door_cycles got %0d want 5", opens); end
        checks++;
        if (fail_count !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL success_after got fail=%0d in_ready=%b want 0 1", fail_count, in_ready);
        end
        $display("success: door_open cycles=%0d fail_count=%0d", opens, fail_count);
    endtask

    task automatic test_lockout();
        int locked;
        for (int i = 1; i <= 3; i++) begin
            drive_attempt(4'b1010);
            pwd_incorrect = 1'b1;
            tick();
            pwd_incorrect = 1'b0;
            checks++;
            if (fail_count !== 2'(i) || alarm !== (i == 3)) begin
                errors++; $display("FAIL lockout_fail%0d got fail=%0d alarm=%b want %0d %b", i, fail_count, alarm, i, i == 3);
            end
            $display("lockout: attempt %0d fail_count=%0d alarm=%b", i, fail_count, alarm);
        end
        in_valid = 1'b1; in_data = 4'b0110;
        locked = locked_out ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (locked_out === 1'b1) locked++;
            checks++;
            if (in_ready !== 1'b0 || alarm !== 1'b0) begin
                errors++; $display("FAIL lockout_hold c%0d got in_ready=%b alarm=%b want 0 0", i, in_ready, alarm);
            end
        end
        checks++;
        if (locked != 20) begin errors++; $display("FAIL lockout_cycles got %0d want 20", locked); end
        tick();
        checks++;
        if (locked_out !== 1'b0 || fail_count !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL lockout_exit got lock=%b fail=%0d in_ready=%b want 0 0 1", locked_out, fail_count, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (p_valid !== 1'b1 || p_data !== 4'b0110) begin
            errors++; $display("FAIL lockout_held_word got p_valid=%b p_data=%b want 1 0110", p_valid, p_data);
        end
        tick();
        unlock = 1'b1;
        tick();
        unlock = 1'b0;
        repeat (5) tick();
        checks++;
        if (in_ready !== 1'b1 || door_open !== 1'b0) begin
            errors++; $display("FAIL lockout_recover got in_ready=%b door=%b want 1 0", in_ready, door_open);
        end
        $display("lockout: locked cycles=%0d held word=0110", locked);
    endtask

    task automatic test_backpressure();
        p_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'b0011;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (p_valid !== 1'b1 || p_data !== 4'b0011) begin
                errors++; $display("FAIL bp_hold c%0d got p_valid=%b p_data=%b want 1 0011", i, p_valid, p_data);
            end
            tick();
        end
        p_ready = 1'b1;
        tick();
        checks++;
        if (p_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got p_valid=%b want 0", p_valid); end
        unlock = 1'b1; pwd_incorrect = 1'b1;
        tick();
        unlock = 1'b0; pwd_incorrect = 1'b0;
        checks++;
        if (fail_count !== 2'd1 || door_open !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL both_edges got fail=%0d door=%b in_ready=%b want 1 0 1", fail_count, door_open, in_ready);
        end
        $display("backpressure: word held 6 cycles, both edges -> fail_count=%0d", fail_count);
    endtask

    task automatic test_level_hold();
        drive_attempt(4'b0101);
        unlock = 1'b1;
        tick();
        checks++;
        if (door_open !== 1'b1 || fail_count !== 2'd0) begin
            errors++; $display("FAIL level_first got door=%b fail=%0d want 1 0", door_open, fail_count);
        end
        repeat (5) tick();
        drive_attempt(4'b0111);
        tick(); tick(); tick();
        checks++;
        if (door_open !== 1'b0 || in_ready !== 1'b0 || p_valid !== 1'b0) begin
            errors++; $display("FAIL level_no_edge got door=%b in_ready=%b p_valid=%b want 0 0 0", door_open, in_ready, p_valid);
        end
        unlock = 1'b0;
        tick();
        unlock = 1'b1;
        tick();
        unlock = 1'b0;
        checks++;
        if (door_open !== 1'b1) begin errors++; $display("FAIL level_new_edge got door=%b want 1", door_open); end
        repeat (5) tick();
        $display("level_hold: held unlock ignored, fresh edge opened door");
    endtask

    task automatic test_reset_mid();
        p_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'b1001;
        tick();
        in_valid = 1'b0;
        checks++;
        if (p_valid !== 1'b1) begin errors++; $display("FAIL rstmid_forward got p_valid=%b want 1", p_valid); end
        rst = 1'b1;
        tick();
        checks++;
        if (p_valid !== 1'b0 || p_data !== 4'h0 || in_ready !== 1'b0 || fail_count !== 2'd0) begin
            errors++; $display("FAIL rstmid_fwd_clear got p_valid=%b p_data=%b in_ready=%b fail=%0d want 0 0000 0 0",
                               p_valid, p_data, in_ready, fail_count);
        end
        rst = 1'b0; p_ready = 1'b1;
        tick();
        drive_attempt(4'b1111);
        unlock = 1'b1;
        tick();
        unlock = 1'b0;
        checks++;
        if (door_open !== 1'b1) begin errors++; $display("FAIL rstmid_open got door=%b want 1", door_open); end
        rst = 1'b1;
        tick();
        checks++;
        if (door_open !== 1'b0 || in_ready !== 1'b0 || fail_count !== 2'd0) begin
            errors++; $display("FAIL rstmid_open_clear got door=%b in_ready=%b fail=%0d want 0 0 0", door_open, in_ready, fail_count);
        end
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (door_open !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_after got door=%b in_ready=%b want 0 1", door_open, in_ready);
        end
        $display("reset_mid: FORWARD and OPEN abandoned");
    endtask

    task automatic test_timeout();
        drive_attempt(4'b0001);
`ifdef ATTEMPT_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (attempt_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early c%0d got %b want 0", i, attempt_timeout); end
        end
        tick();
        checks++;
        if (attempt_timeout !== 1'b1 || fail_count !== 2'd1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_fire got to=%b fail=%0d in_ready=%b want 1 1 1", attempt_timeout, fail_count, in_ready);
        end
        tick();
        checks++;
        if (attempt_timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b want 0", attempt_timeout); end
        $display("timeout: fired after 8 cycles, fail_count=%0d", fail_count);
`else
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (attempt_timeout !== 1'b0) begin errors++; $display("FAIL timeout_tied c%0d got %b want 0", i, attempt_timeout); end
        end
        checks++;
        if (in_ready !== 1'b0 || fail_count !== 2'd0) begin
            errors++; $display("FAIL timeout_waiting got in_ready=%b fail=%0d want 0 0", in_ready, fail_count);
        end
        pwd_incorrect = 1'b1;
        tick();
        pwd_incorrect = 1'b0;
        checks++;
        if (fail_count !== 2'd1) begin errors++; $display("FAIL timeout_late_result got fail=%0d want 1", fail_count); end
        $display("timeout: disabled, waited 12 cycles, fail_count=%0d", fail_count);
`endif
    endtask

    initial begin
        test_reset();
        test_success();
        test_lockout();
        test_backpressure();
        test_level_hold();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unlock_attempt_guard.md
Name: unlock_attempt_guard

Overview:
Attempt gatekeeper placed directly upstream of integrated_unlocking_system. It accepts one N-bit code word per attempt from the keypad side, forwards it over the p_data/p_valid/p_ready handshake, and consumes the system's unlock/pwd_incorrect result. It counts consecutive failures, enforces a lockout window after MAX_FAILS failures, and drives a timed door_open pulse on success.

Parameters:
N, 4, code word width; must match the downstream unlocking system.
MAX_FAILS, 3, consecutive failures that trigger lockout; must be at least 1.
LOCKOUT_CYCLES, 1000, clock cycles spent in lockout.
UNLOCK_HOLD_CYCLES, 50, clock cycles door_open stays high.
RESULT_TIMEOUT, 64, cycles to wait for a result after the handoff (used only with the optional feature).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_data  input  N  code word from keypad side
in_valid  input  1  in_data valid
in_ready  output  1  guard can accept a word
p_data  output  N  word to the unlocking system
p_valid  output  1  p_data valid
p_ready  input  1  unlocking system accepts the word
unlock  input  1  result from the unlocking system: correct code
pwd_incorrect  input  1  result from the unlocking system: wrong code
door_open  output  1  high for UNLOCK_HOLD_CYCLES after a success
locked_out  output  1  high throughout lockout
fail_count  output  $clog2(MAX_FAILS+1)  consecutive failures so far
alarm  output  1  one-cycle pulse on lockout entry
attempt_timeout  output  1  one-cycle pulse when a result times out

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst. All state updates on the rising edge of clk.
- Reset values: in_ready=0, p_valid=0, p_data=0, door_open=0, locked_out=0, fail_count=0, alarm=0, attempt_timeout=0. Both edge-detect registers are 0 and the FSM is in IDLE.
- Reset mid-operation: abandon the attempt and drop p_valid in the same edge. No result is counted.
- Edge detect: unlock_q and incorrect_q register their inputs every cycle. A result is a rising edge (input high, _q low), sampled only in WAIT_RESULT. Edges seen in other states are ignored.
- FSM states: IDLE, FORWARD, WAIT_RESULT, OPEN, LOCKOUT.
- IDLE:
  - in_ready=1.
  - On in_valid and in_ready: register in_data into hold_reg, then go to FORWARD.
- FORWARD:
  - p_valid=1 and p_data=hold_reg, stable until accepted. in_ready=0.
  - On p_valid and p_ready: go to WAIT_RESULT and clear the wait counter. p_valid is 0 next cycle.
- WAIT_RESULT:
  - in_ready=0.
  - unlock edge alone: fail_count is cleared to 0, the hold counter is cleared, and the FSM goes to OPEN.
  - pwd_incorrect edge, or both edges in the same cycle: counted as a failure (fail-safe).
- Failure handling:
  - fail_count increments, saturating at MAX_FAILS.
  - If the new count equals MAX_FAILS: alarm pulses for one cycle, the lockout counter is cleared, and the FSM goes to LOCKOUT.
  - Otherwise the FSM returns to IDLE.
- OPEN:
  - door_open=1 and in_ready=0.
  - After exactly UNLOCK_HOLD_CYCLES cycles high, go to IDLE with door_open=0.
- LOCKOUT:
  - locked_out=1 and in_ready=0. in_valid is not consumed; the upstream word is held off.
  - After LOCKOUT_CYCLES cycles: fail_count goes to 0, locked_out goes to 0, and the FSM returns to IDLE.
- Counters are sized $clog2 of their max+1 and do not wrap. fail_count never exceeds MAX_FAILS.
- Latency: a word accepted in IDLE at edge k presents p_valid starting the cycle after edge k.

Optional Feature:
ATTEMPT_TIMEOUT_EN
- Defined: in WAIT_RESULT, the wait counter increments each cycle. If RESULT_TIMEOUT cycles elapse with no edge, attempt_timeout pulses for one cycle and the attempt is treated as a failure, including possible lockout entry. An edge arriving on the timeout cycle takes priority over the timeout.
- Undefined: WAIT_RESULT waits indefinitely, attempt_timeout is tied to 0, and no wait counter is synthesised.

Test Plan:
- Bench settings: N=4, MAX_FAILS=3, LOCKOUT_CYCLES=20, UNLOCK_HOLD_CYCLES=5, RESULT_TIMEOUT=8.
- Success: send in_data=4'b1101, hold p_ready=1, pulse unlock 3 cycles after the handoff. Expect p_data=1101 for one cycle, then door_open high for exactly 5 cycles, fail_count=0, and in_ready=1 afterwards.
- Lockout: three words 4'b1010, each answered by a pwd_incorrect pulse. Expect fail_count 1, 2, 3; one alarm pulse on the third; locked_out high for 20 cycles with in_ready=0 while in_valid is held high; then fail_count=0 and the held word is accepted.
- Backpressure, simultaneous results, level hold: hold p_ready=0 for 6 cycles. Expect p_valid=1 with p_data unchanged throughout. Then assert unlock and pwd_incorrect in the same cycle: expect a failure and no door_open. Then hold unlock high across two attempts: the second attempt sees no edge.
- Reset mid-attempt: assert rst in FORWARD and in OPEN. Expect all outputs at their reset values at the next edge and no fail_count change.
- Timeout (ATTEMPT_TIMEOUT_EN defined): no result for 8 cycles. Expect an attempt_timeout pulse and fail_count going 0 to 1. Without the macro: attempt_timeout stays 0 and the FSM stays in WAIT_RESULT.
